// File: rtl/snake_pkg.sv
// Shared types and helpers for the 8x8 snake game-tick sequencer.
// Coordinates: x selects the framebuffer row, y selects the bit (column) within it.
package snake_pkg;

  localparam int unsigned FB_ROWS          = 8;
  localparam int unsigned MAX_LEN_DEFAULT  = 16;
  localparam int unsigned INIT_LEN_DEFAULT = 3;

  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    DOWN  = 2'b01,
    UP    = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } coord_t;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_CALC     = 3'd1;
  localparam state_t ST_CHECK    = 3'd2;
  localparam state_t ST_UPDATE   = 3'd3;
  localparam state_t ST_GAMEOVER = 3'd4;

  // The encoding pairs opposites as bitwise complements.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(~d);
  endfunction

  // One step in direction d; 3-bit arithmetic wraps at the walls.
  function automatic coord_t step_coord(input coord_t c, input dir_t d);
    coord_t n;
    n = c;
    case (d)
      RIGHT:   n.x = c.x + 3'd1;
      LEFT:    n.x = c.x - 3'd1;
      DOWN:    n.y = c.y - 3'd1;
      UP:      n.y = c.y + 3'd1;
      default: n = c;
    endcase
    return n;
  endfunction

  // Reset image of one framebuffer row: body laid along y=0, x=0..init_len-1.
  function automatic logic [7:0] init_fb_row(input int unsigned row, input int unsigned init_len);
    logic [7:0] v;
    v = '0;
    for (int unsigned i = 0; i < init_len; i++) begin
      if ((i % FB_ROWS) == row) v[0] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/snake_body_ring.sv
// Ring buffer of body coordinates, tail at tail_ptr, head at head_ptr.
// Push and pop may occur in the same cycle; the reset image is the initial straight body.
module snake_body_ring
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN  = MAX_LEN_DEFAULT,
  parameter int unsigned INIT_LEN = INIT_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       push,
  input  logic       pop,
  input  coord_t     push_data,
  output coord_t     head,
  output coord_t     tail,
  output logic [6:0] count
);

  localparam int unsigned PW = $clog2(MAX_LEN);

  coord_t          mem_q [MAX_LEN];
  logic [PW-1:0]   head_ptr_q;
  logic [PW-1:0]   tail_ptr_q;
  logic [6:0]      count_q;
  logic [PW-1:0]   wr_ptr;

  assign wr_ptr = head_ptr_q + PW'(1);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        mem_q[i] <= (i < INIT_LEN) ? coord_t'{x: 3'(i), y: 3'd0} : coord_t'('0);
      end
      head_ptr_q <= PW'(INIT_LEN - 1);
      tail_ptr_q <= '0;
      count_q    <= 7'(INIT_LEN);
    end else begin
      if (push) begin
        mem_q[wr_ptr] <= push_data;
        head_ptr_q    <= wr_ptr;
      end
      if (pop) tail_ptr_q <= tail_ptr_q + PW'(1);
      count_q <= count_q + 7'(push) - 7'(pop);
    end
  end

  assign head  = mem_q[head_ptr_q];
  assign tail  = mem_q[tail_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/snake_move_ctrl.sv
// Game-tick sequencer: latches direction, computes the wrapped next head, checks collision,
// then updates the body ring and the 8x8 framebuffer served to the row scanner.
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN  = MAX_LEN_DEFAULT,
  parameter int unsigned INIT_LEN = INIT_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       move_tick,
  input  logic [3:0] direction,
  input  logic       grow,
  input  logic [2:0] row_sel,
  output logic [7:0] row_data,
  output logic [2:0] head_x,
  output logic [2:0] head_y,
  output logic [6:0] length,
  output logic       busy,
  output logic       move_done,
  output logic       game_over
);

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  dir_t       req_dir;
  logic       req_vld;
  logic       pend_q, pend_d;
  coord_t     next_q;
  logic       eat_q;
  logic [7:0] fb_q [FB_ROWS];
  logic [7:0] row_data_q;
  logic       move_done_q;
  logic       game_over_q;

  coord_t     ring_head, ring_tail;
  logic [6:0] ring_count;
  logic       ring_push, ring_pop;

  logic       eat, hit, tail_chase, collide;

  snake_body_ring #(
    .MAX_LEN  (MAX_LEN),
    .INIT_LEN (INIT_LEN)
  ) u_ring (
    .clk       (clk),
    .clear_n   (clear_n),
    .push      (ring_push),
    .pop       (ring_pop),
    .push_data (next_q),
    .head      (ring_head),
    .tail      (ring_tail),
    .count     (ring_count)
  );

  // Button priority right > left > down > up; a reversal request is dropped, not demoted.
  always_comb begin
    req_vld = 1'b1;
    req_dir = RIGHT;
    if (direction[3])      req_dir = RIGHT;
    else if (direction[0]) req_dir = LEFT;
    else if (direction[1]) req_dir = DOWN;
    else if (direction[2]) req_dir = UP;
    else                   req_vld = 1'b0;

    dir_d = dir_q;
    if (state_q == ST_IDLE && req_vld && req_dir != opposite(dir_q)) dir_d = req_dir;
  end

  // Moving onto the tail cell is legal only when the tail vacates it this move.
  always_comb begin
    eat        = pend_q && (ring_count < 7'(MAX_LEN));
    hit        = fb_q[next_q.x][next_q.y];
    tail_chase = (next_q == ring_tail) && !eat;
    collide    = hit && !tail_chase;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (move_tick) state_d = ST_CALC;
      ST_CALC:     state_d = ST_CHECK;
      ST_CHECK:    state_d = collide ? ST_GAMEOVER : ST_UPDATE;
      ST_UPDATE:   state_d = ST_IDLE;
      ST_GAMEOVER: state_d = ST_GAMEOVER;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_UPDATE) pend_d = 1'b0;
    if (grow) pend_d = 1'b1;
  end

  assign ring_push = (state_q == ST_UPDATE);
  assign ring_pop  = (state_q == ST_UPDATE) && !eat_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      dir_q       <= RIGHT;
      pend_q      <= 1'b0;
      next_q      <= '0;
      eat_q       <= 1'b0;
      move_done_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      move_done_q <= (state_q == ST_UPDATE);
      if (state_q == ST_CALC)  next_q <= step_coord(ring_head, dir_q);
      if (state_q == ST_CHECK) begin
        eat_q <= eat;
        if (collide) game_over_q <= 1'b1;
      end
    end
  end

  // Framebuffer: tail erase then head draw, so the draw wins when both hit one cell.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int unsigned r = 0; r < FB_ROWS; r++) fb_q[r] <= init_fb_row(r, INIT_LEN);
      row_data_q <= ~init_fb_row(0, INIT_LEN);
    end else begin
      if (state_q == ST_UPDATE) begin
        if (!eat_q) fb_q[ring_tail.x][ring_tail.y] <= 1'b0;
        fb_q[next_q.x][next_q.y] <= 1'b1;
      end
      row_data_q <= ~fb_q[row_sel];
    end
  end

  assign row_data  = row_data_q;
  assign head_x    = ring_head.x;
  assign head_y    = ring_head.y;
  assign length    = ring_count;
  assign busy      = (state_q == ST_CALC) || (state_q == ST_CHECK) || (state_q == ST_UPDATE);
  assign move_done = move_done_q;
  assign game_over = game_over_q;

endmodule
